// File: rtl/path_reader_if.sv
// Playback bus between the path_reader and its controller / list storage.
// Controller side is master; path_reader side is slave.
interface path_reader_if #(
  parameter int WIDTH = 2,
  parameter int COORD = 4
);
  logic             start;
  logic             en_read;
  logic             item_valid;
  logic [WIDTH-1:0] item_data;
  logic             read_done_in;
  logic [COORD-1:0] pos_row;
  logic [COORD-1:0] pos_col;
  logic             pos_valid;
  logic [8:0]       count;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, item_valid, item_data, read_done_in,
    input  en_read, pos_row, pos_col, pos_valid, count, busy, done, error
  );

  modport slave (
    input  start, item_valid, item_data, read_done_in,
    output en_read, pos_row, pos_col, pos_valid, count, busy, done, error
  );
endinterface

// File: rtl/path_reader.sv
// Replays a stored direction list as a walk on a 2^COORD grid; pos_valid follows item_valid by 1 cycle.
// No backpressure: storage pushes items freely, a silent stream is cut off after TIMEOUT idle cycles.
module path_reader #(
  parameter int WIDTH   = 2,
  parameter int COORD   = 4,
  parameter int TIMEOUT = 64
) (
  input logic          CLK,
  input logic          RST,
  path_reader_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int             IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT - 1);
  localparam logic [COORD-1:0] CMAX   = '1;

  logic [1:0]       state_q, state_d;
  logic [COORD-1:0] row_q, row_d, col_q, col_d;
  logic [8:0]       count_q, count_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             err_q, err_d;
  logic             en_read_q, en_read_d;
  logic             pos_valid_q, pos_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [COORD-1:0] mv_row, mv_col;
  logic             mv_oob;

  // Candidate move; an out-of-range move leaves the position where it is.
  always_comb begin
    mv_row = row_q;
    mv_col = col_q;
    mv_oob = 1'b0;
    case (bus.item_data[1:0])
      2'b00: if (row_q == '0)  mv_oob = 1'b1; else mv_row = row_q - 1'b1;
      2'b01: if (col_q == CMAX) mv_oob = 1'b1; else mv_col = col_q + 1'b1;
      2'b10: if (col_q == '0)  mv_oob = 1'b1; else mv_col = col_q - 1'b1;
      default: if (row_q == CMAX) mv_oob = 1'b1; else mv_row = row_q + 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    count_d     = count_q;
    idle_d      = idle_q;
    err_d       = err_q;
    busy_d      = busy_q;
    en_read_d   = 1'b0;
    pos_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d     = '0;
          col_d     = '0;
          count_d   = '0;
          err_d     = 1'b0;
          en_read_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        idle_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (bus.item_valid) begin
          row_d       = mv_row;
          col_d       = mv_col;
          err_d       = err_q | mv_oob;
          pos_valid_d = 1'b1;
          count_d     = (count_q == 9'h1FF) ? count_q : count_q + 9'd1;
          idle_d      = '0;
        end
        // A final item arriving with read_done_in has already been applied above.
        if (bus.read_done_in) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (!bus.item_valid) begin
          if (idle_q == IDLE_MAX) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      count_q     <= '0;
      idle_q      <= '0;
      err_q       <= 1'b0;
      en_read_q   <= 1'b0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      en_read_q   <= en_read_d;
      pos_valid_q <= pos_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.en_read   = en_read_q;
  assign bus.pos_row   = row_q;
  assign bus.pos_col   = col_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;
endmodule

// File: tb/tb_path_reader.sv
// Scoreboard bench for path_reader: stimulus pushes expected pos/done events, a negedge monitor pops and compares.
module tb_path_reader;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   en_cnt = 0;
  int   exp_q[$];

  path_reader_if #(.WIDTH(2), .COORD(4)) bus ();

  path_reader #(.WIDTH(2), .COORD(4), .TIMEOUT(64)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic int pk(input int kind, input int row, input int col, input int cnt, input int err);
    return (kind << 18) | (row << 14) | (col << 10) | (cnt << 1) | err;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ev(input int kind, input int row, input int col, input int cnt, input int err);
    exp_q.push_back(pk(kind, row, col, cnt, err));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_play;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  task automatic send(input logic [1:0] code, input logic last);
    bus.item_valid   = 1'b1;
    bus.item_data    = code;
    bus.read_done_in = last;
    tick();
    bus.item_valid   = 1'b0;
    bus.read_done_in = 1'b0;
  endtask

  task automatic close_stream;
    bus.read_done_in = 1'b1;
    tick();
    bus.read_done_in = 1'b0;
  endtask

  task automatic check_en(input int n);
    chk("en_read_pulses", en_cnt, n);
    en_cnt = 0;
  endtask

  task automatic mon_evt(input int kind);
    int act;
    act = pk(kind, int'(bus.pos_row), int'(bus.pos_col), int'(bus.count), int'(bus.error));
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_evt: got 0x%0h, expected no event", act);
    end else begin
      chk(kind ? "done_evt" : "pos_evt", act, exp_q.pop_front());
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (bus.en_read) en_cnt++;
      if (bus.pos_valid) mon_evt(0);
      if (bus.done) mon_evt(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    bus.start        = 1'b0;
    bus.item_valid   = 1'b0;
    bus.item_data    = 2'b00;
    bus.read_done_in = 1'b0;
    #12;
    chk("rst_row", int'(bus.pos_row), 0);
    chk("rst_col", int'(bus.pos_col), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_en_read", int'(bus.en_read), 0);
    chk("rst_pos_valid", int'(bus.pos_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_error", int'(bus.error), 0);
    #10;
    RST = 1'b1;

    // Basic walk, start honoured on the first edge after reset release.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("first_start_en_read", int'(bus.en_read), 1);
    chk("first_start_busy", int'(bus.busy), 1);
    tick();
    chk("stream_en_read_low", int'(bus.en_read), 0);
    ev(0, 0, 1, 1, 0); send(2'b01, 1'b0);
    ev(0, 0, 2, 2, 0); send(2'b01, 1'b0);
    ev(0, 1, 2, 3, 0); send(2'b11, 1'b0);
    ev(0, 2, 2, 4, 0); send(2'b11, 1'b0);
    ev(0, 3, 2, 5, 0); send(2'b11, 1'b0);
    ev(1, 3, 2, 5, 0); close_stream();
    tick();
    chk("walk_busy_idle", int'(bus.busy), 0);
    chk("walk_hold_row", int'(bus.pos_row), 3);
    chk("walk_hold_count", int'(bus.count), 5);
    check_en(1);

    // Out-of-bounds up move from the origin.
    begin_play();
    ev(0, 0, 0, 1, 1); send(2'b00, 1'b0);
    ev(1, 0, 0, 1, 1); close_stream();
    tick();
    chk("oob_error_sticky", int'(bus.error), 1);
    check_en(1);

    // Last item together with read_done_in; error cleared by start.
    begin_play();
    chk("start_clears_error", int'(bus.error), 0);
    ev(0, 1, 0, 1, 0); send(2'b11, 1'b0);
    ev(0, 1, 1, 2, 0);
    ev(1, 1, 1, 2, 0); send(2'b01, 1'b1);
    tick();
    check_en(1);

    // Items and read_done_in in IDLE are ignored.
    bus.item_valid = 1'b1; bus.item_data = 2'b01; bus.read_done_in = 1'b1;
    repeat (3) tick();
    bus.item_valid = 1'b0; bus.read_done_in = 1'b0;
    chk("idle_ignore_count", int'(bus.count), 2);
    chk("idle_ignore_col", int'(bus.pos_col), 1);

    // Timeout after 64 silent STREAM cycles.
    begin_play();
    repeat (63) tick();
    chk("timeout_not_early_busy", int'(bus.busy), 1);
    chk("timeout_not_early_err", int'(bus.error), 0);
    ev(1, 0, 0, 0, 1);
    tick();
    tick();
    chk("timeout_idle_busy", int'(bus.busy), 0);
    chk("timeout_error", int'(bus.error), 1);
    check_en(1);

    // Reset in the middle of a stream.
    begin_play();
    ev(0, 0, 1, 1, 0); send(2'b01, 1'b0);
    ev(0, 0, 2, 2, 0); send(2'b01, 1'b0);
    ev(0, 1, 2, 3, 0); send(2'b11, 1'b0);
    tick();
    check_en(1);
    RST = 1'b0;
    #1;
    chk("mid_rst_row", int'(bus.pos_row), 0);
    chk("mid_rst_col", int'(bus.pos_col), 0);
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    tick();
    tick();
    #2;
    RST = 1'b1;
    tick();
    chk("mid_rst_no_done", exp_q.size(), 0);

    // start held high: one en_read per playback, restart only via IDLE.
    bus.start = 1'b1;
    tick();
    chk("held_en_read", int'(bus.en_read), 1);
    tick();
    ev(0, 1, 0, 1, 0);
    ev(1, 1, 0, 1, 0); send(2'b11, 1'b1);
    tick();
    chk("held_back_idle", int'(bus.busy), 0);
    check_en(1);
    tick();
    chk("held_restart_busy", int'(bus.busy), 1);
    chk("held_restart_en_read", int'(bus.en_read), 1);
    bus.start = 1'b0;
    tick();
    ev(1, 0, 0, 0, 0); close_stream();
    tick();
    check_en(1);

    // Count saturates at 511.
    begin_play();
    for (int i = 1; i <= 512; i++) begin
      ev(0, i % 2, 0, (i > 511) ? 511 : i, 0);
      if (i == 512) ev(1, 0, 0, 511, 0);
      send((i % 2) ? 2'b11 : 2'b00, i == 512);
    end
    tick();
    chk("sat_count", int'(bus.count), 511);

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
